// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// mul_seq_ctrl - sequencing controller for a fixed-latency RV64M multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_seq_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int MUL_LATENCY = 3
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Flush,
  input  logic                      ReqValid,
  output logic                      ReqReady,
  input  logic [2:0]                ReqOp,
  input  logic [DATA_WIDTH-1:0]     ReqRs1,
  input  logic [DATA_WIDTH-1:0]     ReqRs2,
  input  logic [4:0]                ReqRd,
  output logic                      MulStart,
  output logic [DATA_WIDTH:0]       MulOpA,
  output logic [DATA_WIDTH:0]       MulOpB,
  input  logic [2*DATA_WIDTH-1:0]   MulProduct,
  output logic                      HoldToEx,
  output logic                      RespValid,
  input  logic                      RespReady,
  output logic [DATA_WIDTH-1:0]     RespData,
  output logic [4:0]                RespRd
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] c_lastCount = CNT_W'(MUL_LATENCY);

  localparam logic [2:0] c_opMul    = 3'b000;
  localparam logic [2:0] c_opMulh   = 3'b001;
  localparam logic [2:0] c_opMulhsu = 3'b010;
  localparam logic [2:0] c_opMulhu  = 3'b011;
  localparam logic [2:0] c_opMulw   = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_count;
  logic [2:0]             r_op;
  logic [4:0]             r_rd;
  logic [DATA_WIDTH:0]    w_extA;
  logic [DATA_WIDTH:0]    w_extB;
  logic [DATA_WIDTH-1:0]  w_result;
  logic                   w_accept;

  assign ReqReady = (r_state == IDLE) && !Flush;
  assign HoldToEx = (r_state == CALC) || ((r_state == DONE) && !RespReady);
  assign w_accept = ReqValid && ReqReady;

  // Operands are widened to 65 bits so one signed multiplier serves every op.
  always_comb begin
    w_extA = {1'b0, ReqRs1};
    w_extB = {1'b0, ReqRs2};
    case (ReqOp)
      c_opMul, c_opMulh: begin
        w_extA = {ReqRs1[DATA_WIDTH-1], ReqRs1};
        w_extB = {ReqRs2[DATA_WIDTH-1], ReqRs2};
      end
      c_opMulhsu: begin
        w_extA = {ReqRs1[DATA_WIDTH-1], ReqRs1};
      end
      c_opMulw: begin
        w_extA = {{(DATA_WIDTH-31){ReqRs1[31]}}, ReqRs1[31:0]};
        w_extB = {{(DATA_WIDTH-31){ReqRs2[31]}}, ReqRs2[31:0]};
      end
      default: begin
        w_extA = {1'b0, ReqRs1};
        w_extB = {1'b0, ReqRs2};
      end
    endcase
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      c_opMul:                          w_result = MulProduct[DATA_WIDTH-1:0];
      c_opMulh, c_opMulhsu, c_opMulhu:  w_result = MulProduct[2*DATA_WIDTH-1:DATA_WIDTH];
      c_opMulw:                         w_result = {{(DATA_WIDTH-32){MulProduct[31]}}, MulProduct[31:0]};
      default:                          w_result = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      MulStart  <= 1'b0;
      MulOpA    <= '0;
      MulOpB    <= '0;
      RespValid <= 1'b0;
      RespData  <= '0;
      RespRd    <= '0;
    end else if (Flush) begin
      r_state   <= IDLE;
      MulStart  <= 1'b0;
      RespValid <= 1'b0;
    end else begin
      MulStart <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= CALC;
            r_count  <= '0;
            r_op     <= ReqOp;
            r_rd     <= ReqRd;
            MulOpA   <= w_extA;
            MulOpB   <= w_extB;
            MulStart <= 1'b1;
          end
        end
        CALC: begin
          // Datapath latency is fixed, so the count alone marks a valid product.
          if (r_count == c_lastCount) begin
            r_state   <= DONE;
            RespValid <= 1'b1;
            RespData  <= w_result;
            RespRd    <= r_rd;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        DONE: begin
          if (RespReady) begin
            r_state   <= IDLE;
            RespValid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
